// File: rtl/ttl_latch_writer_sync.sv
// ttl_latch_writer_sync
//
// Transmitting side of a 74374-style synchronous inter-CPU / sound latch.
// A CPU write is presented on LATCH_D and followed by a single clean
// low -> high -> low strobe on LATCH_CEN, so the receiving latch sees exactly
// one rising enable per byte. A one-entry queue absorbs a write that arrives
// while a strobe sequence is running. PENDING tracks whether the reader has
// consumed the last strobed byte, and OVERRUN flags lost or overwritten bytes.
//
// Ports:
//   Clk        in   system clock, all logic on the rising edge
//   RESETn     in   asynchronous active-low reset
//   CPU_Cen    in   CPU clock enable; WR_REQ is ignored while low
//   WR_REQ     in   write request
//   WR_DATA    in   [7:0] byte to send
//   ACK        in   reader pulse: byte consumed (clears PENDING)
//   OVR_CLR    in   clears OVERRUN
//   LATCH_D    out  [7:0] data to the latch D inputs
//   LATCH_CEN  out  strobe to the latch clock enable
//   BUSY       out  strobe sequence in progress
//   PENDING    out  byte strobed but not yet acknowledged
//   OVERRUN    out  sticky error flag
//
// All outputs come straight from flops.

module ttl_latch_writer_sync #(
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned HOLD_CYC   = 1
) (
   input  logic       Clk,
   input  logic       RESETn,
   input  logic       CPU_Cen,
   input  logic       WR_REQ,
   input  logic [7:0] WR_DATA,
   input  logic       ACK,
   input  logic       OVR_CLR,
   output logic [7:0] LATCH_D,
   output logic       LATCH_CEN,
   output logic       BUSY,
   output logic       PENDING,
   output logic       OVERRUN
);

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StStrobe,
      StHold
   } state_e;

   // Counter reload values: each state lasts (load + 1) cycles.
   localparam logic [3:0] SetupLd  = 4'(SETUP_CYC - 1);
   localparam logic [3:0] StrobeLd = 4'(STROBE_CYC - 1);
   localparam logic [3:0] HoldLd   = 4'(HOLD_CYC - 1);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] data_q, data_d;
   logic [7:0] qdata_q, qdata_d;
   logic       qvalid_q, qvalid_d;
   logic       pend_q, pend_d;
   logic       ovr_q, ovr_d;
   logic       cen_q, busy_q;

   logic       wr_acc;
   logic       cnt_zero;
   logic       strobe_entry;
   logic       ovr_set;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      data_d       = data_q;
      qdata_d      = qdata_q;
      qvalid_d     = qvalid_q;
      strobe_entry = 1'b0;
      ovr_set      = 1'b0;
      wr_acc       = WR_REQ & CPU_Cen;
      cnt_zero     = (cnt_q == 4'd0);

      // Writes while a sequence runs go to the queue, or are lost if it is full.
      if (wr_acc && (state_q != StIdle)) begin
         if (qvalid_q) begin
            ovr_set = 1'b1;
         end else begin
            qvalid_d = 1'b1;
            qdata_d  = WR_DATA;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (wr_acc) begin
               data_d  = WR_DATA;
               cnt_d   = SetupLd;
               state_d = StSetup;
            end
         end
         StSetup: begin
            if (cnt_zero) begin
               cnt_d        = StrobeLd;
               state_d      = StStrobe;
               strobe_entry = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StStrobe: begin
            if (cnt_zero) begin
               cnt_d   = HoldLd;
               state_d = StHold;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StHold: begin
            if (cnt_zero) begin
               if (qvalid_q) begin
                  data_d   = qdata_q;
                  qvalid_d = 1'b0;
                  cnt_d    = SetupLd;
                  state_d  = StSetup;
               end else if (wr_acc) begin
                  // Write landing in the last hold cycle: enqueue and dequeue at once.
                  data_d   = WR_DATA;
                  qvalid_d = 1'b0;
                  cnt_d    = SetupLd;
                  state_d  = StSetup;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Strobing over an unacknowledged byte loses it.
      if (strobe_entry && pend_q) begin
         ovr_set = 1'b1;
      end

      // Set wins over clear for both flags.
      if (strobe_entry) begin
         pend_d = 1'b1;
      end else if (ACK) begin
         pend_d = 1'b0;
      end else begin
         pend_d = pend_q;
      end

      if (ovr_set) begin
         ovr_d = 1'b1;
      end else if (OVR_CLR) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end
   end

   always_ff @(posedge Clk or negedge RESETn) begin
      if (!RESETn) begin
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         data_q   <= 8'h00;
         qdata_q  <= 8'h00;
         qvalid_q <= 1'b0;
         pend_q   <= 1'b0;
         ovr_q    <= 1'b0;
         cen_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         qdata_q  <= qdata_d;
         qvalid_q <= qvalid_d;
         pend_q   <= pend_d;
         ovr_q    <= ovr_d;
         // Decoded from next state so the strobe and busy pins are flops.
         cen_q    <= (state_d == StStrobe);
         busy_q   <= (state_d != StIdle);
      end
   end

   assign LATCH_D   = data_q;
   assign LATCH_CEN = cen_q;
   assign BUSY      = busy_q;
   assign PENDING   = pend_q;
   assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_ttl_latch_writer_sync.sv
// Testbench for ttl_latch_writer_sync. Two instances share the stimulus: one
// with default timing (1/2/1) and one with 3/4/2. A transaction-level model
// schedules each accepted write as a sequence start time; expected strobes are
// queued per instance and a monitor checks each rising LATCH_CEN against them.

module tb_ttl_latch_writer_sync;

   localparam int S0 = 1, T0 = 2, H0 = 1;
   localparam int S1 = 3, T1 = 4, H1 = 2;
   localparam int NoSeq = -100000;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cpu_cen = 1'b0;
   logic            wr_req = 1'b0;
   logic [7:0]      wr_data = 8'h00;
   logic            ack = 1'b0;
   logic            ovr_clr = 1'b0;
   logic [1:0][7:0] ld;
   logic [1:0]      cen, busy, pend, ovr;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] d;
      int         e;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];

   // Model: start edge and byte of the latest two scheduled sequences.
   int         m_last[2], m_prev[2];
   logic [7:0] m_ld[2], m_pd[2];
   bit         m_pend[2], m_ovr[2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ttl_latch_writer_sync #(.SETUP_CYC(S0), .STROBE_CYC(T0), .HOLD_CYC(H0)) u_dut0 (
      .Clk(clk), .RESETn(rst_n), .CPU_Cen(cpu_cen), .WR_REQ(wr_req), .WR_DATA(wr_data),
      .ACK(ack), .OVR_CLR(ovr_clr), .LATCH_D(ld[0]), .LATCH_CEN(cen[0]), .BUSY(busy[0]),
      .PENDING(pend[0]), .OVERRUN(ovr[0])
   );

   ttl_latch_writer_sync #(.SETUP_CYC(S1), .STROBE_CYC(T1), .HOLD_CYC(H1)) u_dut1 (
      .Clk(clk), .RESETn(rst_n), .CPU_Cen(cpu_cen), .WR_REQ(wr_req), .WR_DATA(wr_data),
      .ACK(ack), .OVR_CLR(ovr_clr), .LATCH_D(ld[1]), .LATCH_CEN(cen[1]), .BUSY(busy[1]),
      .PENDING(pend[1]), .OVERRUN(ovr[1])
   );

   function automatic int ps(int i);
      return (i == 0) ? S0 : S1;
   endfunction

   function automatic int pt(int i);
      return (i == 0) ? T0 : T1;
   endfunction

   function automatic int ph(int i);
      return (i == 0) ? H0 : H1;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t cyc=%0d actual=%0d expected=%0d", name, $time, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_last[i] = NoSeq;
         m_prev[i] = NoSeq;
         m_ld[i]   = 8'h00;
         m_pd[i]   = 8'h00;
         m_pend[i] = 1'b0;
         m_ovr[i]  = 1'b0;
      end
      sb0.delete();
      sb1.delete();
   endtask

   // Effect of edge n on instance i given the inputs sampled at that edge.
   task automatic model_edge(int i, int n, bit acc, logic [7:0] d, bit a, bit oc);
      int   len;
      int   st;
      bit   entry;
      bit   drop;
      exp_t e;
      len   = ps(i) + pt(i) + ph(i);
      entry = (n == m_last[i] + ps(i)) || (n == m_prev[i] + ps(i));
      drop  = 1'b0;
      if (acc) begin
         if (m_last[i] >= n) begin
            // A byte is already waiting for the running sequence to end.
            drop = 1'b1;
         end else begin
            st = (n > m_last[i] + len) ? n : m_last[i] + len;
            m_prev[i] = m_last[i];
            m_pd[i]   = m_ld[i];
            m_last[i] = st;
            m_ld[i]   = d;
            e.d = d;
            e.e = st + ps(i);
            if (i == 0) sb0.push_back(e);
            else sb1.push_back(e);
         end
      end
      if (drop || (entry && m_pend[i])) m_ovr[i] = 1'b1;
      else if (oc) m_ovr[i] = 1'b0;
      if (entry) m_pend[i] = 1'b1;
      else if (a) m_pend[i] = 1'b0;
   endtask

   task automatic drive(bit req, bit cc, logic [7:0] d, bit a, bit oc);
      @(negedge clk);
      wr_req  = req;
      cpu_cen = cc;
      wr_data = d;
      ack     = a;
      ovr_clr = oc;
      if (rst_n) begin
         for (int i = 0; i < 2; i++) model_edge(i, cyc + 1, req & cc, d, a, oc);
      end
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic check_reset_outputs(string tag);
      for (int i = 0; i < 2; i++) begin
         chk({tag, "_latch_d"}, int'(ld[i]), 0);
         chk({tag, "_latch_cen"}, int'(cen[i]), 0);
         chk({tag, "_busy"}, int'(busy[i]), 0);
         chk({tag, "_pending"}, int'(pend[i]), 0);
         chk({tag, "_overrun"}, int'(ovr[i]), 0);
      end
   endtask

   // Monitor: per-cycle flag checks and scoreboard pops on each strobe rise.
   initial begin
      bit         pc[2];
      int         hi[2];
      int         s, len, nq;
      logic [7:0] dd;
      bit         eb;
      exp_t       e;
      pc = '{1'b0, 1'b0};
      hi = '{0, 0};
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            pc = '{1'b0, 1'b0};
            hi = '{0, 0};
         end else begin
            for (int i = 0; i < 2; i++) begin
               len = ps(i) + pt(i) + ph(i);
               if (m_last[i] <= cyc) begin
                  s  = m_last[i];
                  dd = m_ld[i];
               end else begin
                  s  = m_prev[i];
                  dd = m_pd[i];
               end
               eb = (cyc >= s) && (cyc < s + len);
               chk($sformatf("busy%0d", i), int'(busy[i]), int'(eb));
               chk($sformatf("latch_d%0d", i), int'(ld[i]), int'(dd));
               chk($sformatf("pending%0d", i), int'(pend[i]), int'(m_pend[i]));
               chk($sformatf("overrun%0d", i), int'(ovr[i]), int'(m_ovr[i]));
               if (cen[i] && !pc[i]) begin
                  nq = (i == 0) ? sb0.size() : sb1.size();
                  chk($sformatf("strobe_expected%0d", i), int'(nq != 0), 1);
                  if (nq != 0) begin
                     e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                     chk($sformatf("strobe_data%0d", i), int'(ld[i]), int'(e.d));
                     chk($sformatf("strobe_edge%0d", i), cyc, e.e);
                  end
               end
               if (cen[i]) begin
                  hi[i]++;
               end else if (pc[i]) begin
                  chk($sformatf("strobe_width%0d", i), hi[i], pt(i));
                  hi[i] = 0;
               end
               pc[i] = cen[i];
            end
         end
      end
   end

   initial begin
      int k;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      drive(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
      idle(14);
      drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
      idle(2);

      drive(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
      idle(24);
      drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
      idle(2);

      drive(1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
      idle(24);
      drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);

      // Request with the CPU enable low must be ignored.
      drive(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 8'hEF, 1'b0, 1'b0);
      idle(3);

      // ACK on the default instance's strobe-entry edge, then a later ACK.
      drive(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
      idle(4);
      drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
      idle(10);
      drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
      idle(2);

      // Reset in the middle of the 3/4/2 instance's strobe.
      drive(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
      k = 0;
      while (!cen[1] && k < 40) begin
         idle(1);
         k++;
      end
      chk("strobe_seen_before_reset", int'(cen[1]), 1);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
      idle(16);
      drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);

      for (int n = 0; n < 1500; n++) begin
         drive(bit'($urandom_range(3) == 0), bit'($urandom_range(3) != 0), 8'($urandom),
               bit'($urandom_range(7) == 0), bit'($urandom_range(15) == 0));
      end
      idle(20);
      chk("sb_drained0", sb0.size(), 0);
      chk("sb_drained1", sb1.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
